// File: rtl/inv_sub_layer_seq_if.sv
// ============================================================================
// Module : inv_sub_layer_seq_if
// Brief  : Handshake and data bundle for the sequential inverse S-box layer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inv_sub_layer_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y0;
    logic [63:0] y1;
    logic [63:0] y2;
    logic [63:0] y3;
    logic [63:0] y4;
    logic        busy;

    modport master (
        output in_valid, x0, x1, x2, x3, x4, out_ready,
        input  in_ready, out_valid, y0, y1, y2, y3, y4, busy
    );

    modport slave (
        input  in_valid, x0, x1, x2, x3, x4, out_ready,
        output in_ready, out_valid, y0, y1, y2, y3, y4, busy
    );
endinterface

`default_nettype wire

// File: rtl/inv_sub_layer_seq.sv
// ============================================================================
// Module : inv_sub_layer_seq
// Brief  : Inverse Ascon substitution layer, SLICES bit-slices per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_sub_layer_seq #(
    parameter int SLICES = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inv_sub_layer_seq_if.slave    bus
);

    localparam int CHUNKS = 64 / SLICES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    generate
        if (SLICES != 1 && SLICES != 2 && SLICES != 4 && SLICES != 8 &&
            SLICES != 16 && SLICES != 32 && SLICES != 64) begin : g_bad_slices
            $error("inv_sub_layer_seq: SLICES must be a power of two in 1..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0][63:0]  w_q, w_d;

    logic [6:0]        w_base;
    logic [6:0]        w_pos;
    logic [4:0]        w_idx;
    logic [4:0]        w_sb;

    function automatic logic [4:0] inv_sbox(input logic [4:0] v);
        logic [4:0] r;
        r = '0;
        case (v)
            5'h00: r = 5'h14;  5'h01: r = 5'h1a;  5'h02: r = 5'h07;  5'h03: r = 5'h0d;
            5'h04: r = 5'h00;  5'h05: r = 5'h09;  5'h06: r = 5'h0e;  5'h07: r = 5'h12;
            5'h08: r = 5'h0a;  5'h09: r = 5'h06;  5'h0a: r = 5'h1d;  5'h0b: r = 5'h01;
            5'h0c: r = 5'h19;  5'h0d: r = 5'h15;  5'h0e: r = 5'h13;  5'h0f: r = 5'h1e;
            5'h10: r = 5'h18;  5'h11: r = 5'h16;  5'h12: r = 5'h0b;  5'h13: r = 5'h11;
            5'h14: r = 5'h03;  5'h15: r = 5'h05;  5'h16: r = 5'h1c;  5'h17: r = 5'h1f;
            5'h18: r = 5'h17;  5'h19: r = 5'h1b;  5'h1a: r = 5'h04;  5'h1b: r = 5'h08;
            5'h1c: r = 5'h0f;  5'h1d: r = 5'h0c;  5'h1e: r = 5'h10;  5'h1f: r = 5'h02;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        w_base  = 7'(cnt_q) * 7'(SLICES);
        w_pos   = '0;
        w_idx   = '0;
        w_sb    = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_d[0]  = bus.x0;
                    w_d[1]  = bus.x1;
                    w_d[2]  = bus.x2;
                    w_d[3]  = bus.x3;
                    w_d[4]  = bus.x4;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Word 0 carries the MSB of each 5-bit slice index.
                for (int j = 0; j < SLICES; j++) begin
                    w_pos = w_base + 7'(j);
                    w_idx = {w_q[0][w_pos[5:0]], w_q[1][w_pos[5:0]], w_q[2][w_pos[5:0]],
                             w_q[3][w_pos[5:0]], w_q[4][w_pos[5:0]]};
                    w_sb  = inv_sbox(w_idx);
                    w_d[0][w_pos[5:0]] = w_sb[4];
                    w_d[1][w_pos[5:0]] = w_sb[3];
                    w_d[2][w_pos[5:0]] = w_sb[2];
                    w_d[3][w_pos[5:0]] = w_sb[1];
                    w_d[4][w_pos[5:0]] = w_sb[0];
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.y0        = w_q[0];
    assign bus.y1        = w_q[1];
    assign bus.y2        = w_q[2];
    assign bus.y3        = w_q[3];
    assign bus.y4        = w_q[4];

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_layer_seq.sv
// ============================================================================
// Module : tb_inv_sub_layer_seq
// Brief  : Self-checking bench: directed cases, reset abort, backpressure,
//          and forward/inverse round trips for SLICES = 1, 8, 64.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inv_sub_layer_seq;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   rt_done = 0;

    always #5 clk = ~clk;

    logic [4:0] inv_tab [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Ascon forward substitution in its usual word-wide boolean form.
    function automatic logic [319:0] fwd_model(input logic [319:0] s);
        logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
        {a0, a1, a2, a3, a4} = s;
        a0 ^= a4; a4 ^= a3; a2 ^= a1;
        t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
        a0 ^= t1; a1 ^= t2; a2 ^= t3; a3 ^= t4; a4 ^= t0;
        a1 ^= a0; a0 ^= a4; a3 ^= a2; a2 = ~a2;
        return {a0, a1, a2, a3, a4};
    endfunction

    function automatic logic [319:0] inv_model(input logic [319:0] s);
        logic [319:0] r;
        logic [4:0]   v;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            v = inv_tab[{s[256+i], s[192+i], s[128+i], s[64+i], s[i]}];
            {r[256+i], r[192+i], r[128+i], r[64+i], r[i]} = v;
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- directed DUT (SLICES = 8) ----------------
    inv_sub_layer_seq_if m_bus();
    inv_sub_layer_seq #(.SLICES(8)) u_dut (.clk(clk), .rst(rst_a), .bus(m_bus.slave));

    function automatic logic [319:0] m_y();
        return {m_bus.y0, m_bus.y1, m_bus.y2, m_bus.y3, m_bus.y4};
    endfunction

    task automatic m_drive(input logic [319:0] xs);
        {m_bus.x0, m_bus.x1, m_bus.x2, m_bus.x3, m_bus.x4} = xs;
    endtask

    task automatic m_wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!m_bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 320'(lat), 320'(exp_lat));
    endtask

    task automatic run_dir(input string tag, input logic [319:0] xs, input logic [319:0] exp);
        @(negedge clk);
        chk({tag, "_in_ready"}, 320'(m_bus.in_ready), 320'(1'b1));
        m_drive(xs);
        m_bus.in_valid  = 1'b1;
        m_bus.out_ready = 1'b1;
        @(posedge clk); #1;
        m_bus.in_valid = 1'b0;
        m_drive(rand_state());
        chk({tag, "_busy"}, 320'(m_bus.busy), 320'(1'b1));
        m_wait_valid(tag, 8);
        chk({tag, "_y"}, m_y(), exp);
        @(posedge clk); #1;
        chk({tag, "_ov_drop"}, 320'(m_bus.out_valid), 320'(1'b0));
    endtask

    initial begin
        logic [319:0] xs, snap;
        logic         seen;
        m_bus.in_valid  = 1'b0;
        m_bus.out_ready = 1'b1;
        m_drive('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("rst_in_ready", 320'(m_bus.in_ready), 320'(1'b1));
        chk("rst_out_valid", 320'(m_bus.out_valid), 320'(1'b0));
        chk("rst_busy", 320'(m_bus.busy), 320'(1'b0));
        chk("rst_y", m_y(), '0);

        run_dir("zero", '0, {{64{1'b1}}, 64'h0, {64{1'b1}}, 64'h0, 64'h0});
        run_dir("ones", {320{1'b1}}, {64'h0, 64'h0, 64'h0, {64{1'b1}}, 64'h0});
        run_dir("x0only", {{64{1'b1}}, 256'h0}, {{64{1'b1}}, {64{1'b1}}, 64'h0, 64'h0, 64'h0});
        for (int n = 0; n < 4; n++) begin
            xs = rand_state();
            run_dir("rand", xs, inv_model(xs));
        end

        // Abort at the third RUN cycle.
        @(negedge clk);
        m_drive(rand_state());
        m_bus.in_valid = 1'b1;
        @(posedge clk); #1;
        m_bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        chk("abort_out_valid", 320'(m_bus.out_valid), 320'(1'b0));
        chk("abort_in_ready", 320'(m_bus.in_ready), 320'(1'b1));
        chk("abort_y", m_y(), '0);
        @(negedge clk);
        rst_a = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (m_bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_pulse", 320'(seen), 320'(1'b0));

        // Backpressure in DONE with in_valid pulses that must be ignored.
        @(negedge clk);
        xs = rand_state();
        m_drive(xs);
        m_bus.in_valid  = 1'b1;
        m_bus.out_ready = 1'b0;
        @(posedge clk); #1;
        m_bus.in_valid = 1'b0;
        m_wait_valid("bp", 8);
        snap = inv_model(xs);
        chk("bp_y", m_y(), snap);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            m_bus.in_valid = (c % 3 == 0);
            m_drive(rand_state());
            @(posedge clk); #1;
            chk("bp_out_valid", 320'(m_bus.out_valid), 320'(1'b1));
            chk("bp_in_ready", 320'(m_bus.in_ready), 320'(1'b0));
            chk("bp_y_stable", m_y(), snap);
        end
        @(negedge clk);
        m_bus.in_valid  = 1'b0;
        m_bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_out_valid", 320'(m_bus.out_valid), 320'(1'b0));
        chk("bp_rel_in_ready", 320'(m_bus.in_ready), 320'(1'b1));
        chk("bp_rel_y_kept", m_y(), snap);
        xs = rand_state();
        run_dir("bp_next", xs, inv_model(xs));

        for (int t = 0; t < 80000 && rt_done < 3; t++) @(posedge clk);
        chk("rt_complete", 320'(rt_done), 320'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- round-trip DUTs ----------------
    for (genvar k = 0; k < 3; k++) begin : g_rt
        localparam int S  = (k == 0) ? 1 : (k == 1) ? 8 : 64;
        localparam int NV = (k == 0) ? 400 : 1000;

        inv_sub_layer_seq_if u_bus();
        inv_sub_layer_seq #(.SLICES(S)) u_dut (.clk(clk), .rst(rst_b), .bus(u_bus.slave));

        initial begin
            logic [319:0] orig;
            int           lat;
            u_bus.in_valid  = 1'b0;
            u_bus.out_ready = 1'b1;
            {u_bus.x0, u_bus.x1, u_bus.x2, u_bus.x3, u_bus.x4} = '0;
            for (int t = 0; t < 50 && (rst_b || t < 2); t++) @(posedge clk);
            for (int n = 0; n < NV; n++) begin
                orig = rand_state();
                @(negedge clk);
                {u_bus.x0, u_bus.x1, u_bus.x2, u_bus.x3, u_bus.x4} = fwd_model(orig);
                u_bus.in_valid = 1'b1;
                @(posedge clk); #1;
                u_bus.in_valid = 1'b0;
                lat = 0;
                while (!u_bus.out_valid && lat < 200) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("rt%0d_lat", S), 320'(lat), 320'(64 / S));
                chk($sformatf("rt%0d_y", S),
                    {u_bus.y0, u_bus.y1, u_bus.y2, u_bus.y3, u_bus.y4}, orig);
                @(posedge clk);
            end
            rt_done++;
        end
    end

endmodule

`default_nettype wire
